// File: rtl/closest_hit_tracker.sv
// Tracks the nearest qualifying ray-hit distance and its object id across a ray's candidate stream.
// Optional macro CLOSEST_HIT_STATS_EN adds a saturating per-ray candidate count output.
module closest_hit_tracker #(
  parameter int unsigned ID_W = 8,
`ifdef CLOSEST_HIT_STATS_EN
  parameter int unsigned CNT_W = 8,
`endif
  parameter logic [31:0] T_MIN = 32'h3A83126F
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_t,
  input  logic [ID_W-1:0] in_id,
  input  logic            in_hit,
  input  logic            in_last,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_t,
  output logic [ID_W-1:0] res_id,
  output logic            res_hit
`ifdef CLOSEST_HIT_STATS_EN
  ,
  output logic [CNT_W-1:0] res_cand_cnt
`endif
);

  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t            state_reg, state_next;
  logic              acc_hit_reg;
  logic [30:0]       best_t_reg;
  logic [ID_W-1:0]   best_id_reg;
  logic [31:0]       res_t_reg;
  logic [ID_W-1:0]   res_id_reg;
  logic              res_hit_reg;

  logic              accept;
  logic              qualify;
  logic              merged_hit;
  logic [30:0]       merged_t;
  logic [ID_W-1:0]   merged_id;

  assign in_ready = (state_reg != HOLD) || res_ready;
  assign accept   = in_valid && in_ready;

  // Positive finite floats order like their magnitude bits, so an unsigned compare suffices.
  assign qualify = in_hit && !in_t[31] && (in_t[30:23] != 8'hFF) &&
                   (in_t[30:0] > T_MIN[30:0]) &&
                   (!acc_hit_reg || (in_t[30:0] < best_t_reg));

  assign merged_hit = acc_hit_reg || qualify;
  assign merged_t   = qualify ? in_t[30:0] : best_t_reg;
  assign merged_id  = qualify ? in_id : best_id_reg;

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = in_last ? HOLD : ACCUM;
    end else if (state_reg == HOLD && res_ready) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      acc_hit_reg <= 1'b0;
      best_t_reg  <= '0;
      best_id_reg <= '0;
      res_t_reg   <= POS_INF;
      res_id_reg  <= '0;
      res_hit_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (in_last) begin
          // Result takes the last beat into account; accumulator restarts empty for the next ray.
          acc_hit_reg <= 1'b0;
          res_hit_reg <= merged_hit;
          res_t_reg   <= merged_hit ? {1'b0, merged_t} : POS_INF;
          res_id_reg  <= merged_hit ? merged_id : '0;
        end else begin
          acc_hit_reg <= merged_hit;
          best_t_reg  <= merged_t;
          best_id_reg <= merged_id;
        end
      end
    end
  end

  assign res_valid = (state_reg == HOLD);
  assign res_t     = res_t_reg;
  assign res_id    = res_id_reg;
  assign res_hit   = res_hit_reg;

`ifdef CLOSEST_HIT_STATS_EN
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] res_cnt_reg;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_reg     <= '0;
      res_cnt_reg <= '0;
    end else if (accept) begin
      if (in_last) begin
        res_cnt_reg <= cnt_inc;
        cnt_reg     <= '0;
      end else begin
        cnt_reg <= cnt_inc;
      end
    end
  end

  assign res_cand_cnt = res_cnt_reg;
`endif

endmodule
